// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t - sequencer state (BOOT bubble, RUN, terminal FAULT)
//   INSTR_W/ADDR_W - instruction and byte-address widths
//   PC_STEP        - sequential PC increment
//   NOP_INSTR      - IF/ID instruction value after reset (decode treats it as a bubble)
//   sat_inc32      - saturating +1 used by the optional performance counters
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 64'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// fetch_addr_chk: combinational legality check of a fetch byte address.
// A fetch is bad when the address is not word aligned or when the last byte of
// the word (pc+3) falls at or beyond MEM_BYTES. The sum is formed one bit wider
// than the address so addresses near the top of the 64-bit space cannot wrap
// back into range.
// Ports:
//   pc  - byte address being fetched
//   bad - 1 when the fetch must fault
module fetch_addr_chk
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [ADDR_W-1:0] pc,
  output logic              bad
);

  localparam logic [ADDR_W:0] Limit = (ADDR_W + 1)'(MEM_BYTES);

  logic [ADDR_W:0] last_byte;

  always_comb begin
    last_byte = {1'b0, pc} + (ADDR_W + 1)'(3);
    bad       = (pc[1:0] != 2'b00) || (last_byte >= Limit);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, presents it to a combinational instruction ROM and captures the
// returned word into the IF/ID register. Later stages can stall it or redirect
// it (which flushes IF/ID). An illegal fetch address sends it into a terminal
// FAULT state that only reset leaves.
// Optional build macro: FETCH_PERF_EN adds saturating performance counters.
// Ports:
//   clk, reset_n    - clock and asynchronous active-low reset
//   instr_addr      - ROM byte address (always the registered PC)
//   instruction     - ROM read data for instr_addr
//   stall           - hold PC and IF/ID this cycle
//   redirect_valid  - flush IF/ID and load redirect_pc
//   redirect_pc     - redirect target byte address
//   if_id_valid/instr/pc - IF/ID pipeline register
//   fault, fault_pc - sticky fetch fault and offending PC
//   perf_fetched, perf_stall_cyc, perf_flushes - counters (FETCH_PERF_EN only)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_flushes
`endif
);

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;

  logic fetch_bad;
  logic take_redirect, take_fault, take_load;

  fetch_addr_chk #(
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_chk (
    .pc (pc_q),
    .bad(fetch_bad)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirect_valid && fetch_bad) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Per-cycle action strobes; RUN priority is redirect > fault > stall > fetch
  always_comb begin
    take_redirect = 1'b0;
    take_fault    = 1'b0;
    take_load     = 1'b0;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        take_redirect = 1'b1;
      end else if (fetch_bad) begin
        take_fault = 1'b1;
      end else if (!stall) begin
        take_load = 1'b1;
      end
    end
  end

  // Datapath next state; everything holds unless a strobe says otherwise
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    if (take_redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end
    if (take_fault) begin
      fault_d = 1'b1;
      fpc_d   = pc_q;
      valid_d = 1'b0;
    end
    if (take_load) begin
      instr_d = instruction;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  assign instr_addr  = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign fault       = fault_q;
  assign fault_pc    = fpc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] flushes_q, flushes_d;
  logic        stall_cyc_hit;

  always_comb begin
    stall_cyc_hit = (state_q == RUN) && !redirect_valid && !fetch_bad && stall;
    fetched_d     = take_load ? sat_inc32(fetched_q) : fetched_q;
    stall_cyc_d   = stall_cyc_hit ? sat_inc32(stall_cyc_q) : stall_cyc_q;
    flushes_d     = take_redirect ? sat_inc32(flushes_q) : flushes_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q   <= '0;
      stall_cyc_q <= '0;
      flushes_q   <= '0;
    end else begin
      fetched_q   <= fetched_d;
      stall_cyc_q <= stall_cyc_d;
      flushes_q   <= flushes_d;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flushes   = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] instr_addr;
  logic [31:0] instruction;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        fault;
  logic [63:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_flushes;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [256];

  always #5 clk = ~clk;

  // Combinational ROM; out-of-range reads return a recognisable garbage word
  assign instruction = (instr_addr < 64'd1024) ? rom[instr_addr[9:2]] : 32'hDEAD_BEEF;

  fetch_ctrl #(
    .MEM_BYTES(1024),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_addr    (instr_addr),
    .instruction   (instruction),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flushes  (perf_flushes)
`endif
  );

  // Reference model state
  logic [63:0] m_pc, m_ipc, m_fpc;
  logic [31:0] m_instr;
  logic        m_valid, m_fault, m_boot;
  int unsigned m_fetched, m_stalls, m_flushes;

  function automatic logic model_bad(input logic [63:0] pc);
    logic [64:0] last;
    last = {1'b0, pc} + 65'd3;
    return (pc[1:0] != 2'b00) || (last >= 65'd1024);
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = '0; m_fpc = '0; m_instr = '0;
    m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
    m_fetched = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // One clock of the specified behaviour, using the inputs currently driven
  task automatic model_step();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_fault) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_valid = 1'b0; m_flushes++;
      end else if (model_bad(m_pc)) begin
        m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0;
      end else if (stall) begin
        m_stalls++;
      end else begin
        m_instr = rom[m_pc[9:2]]; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_fetched++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", instr_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_id_instr); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();  // BOOT bubble
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b want 0", if_id_valid); end
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL boot_addr got %h want 0", instr_addr); end
  endtask

  task automatic test_seq_fetch();
    apply_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_id_pc !== 64'(i * 4) || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL seq_pc got %h/%b want %h/1", if_id_pc, if_id_valid, 64'(i * 4));
      end
      checks++; if (if_id_instr !== rom[i]) begin
        errors++; $display("FAIL seq_instr got %h want %h", if_id_instr, rom[i]);
      end
    end
    checks++; if (instr_addr !== 64'd12) begin errors++; $display("FAIL seq_addr got %h want c", instr_addr); end
  endtask

  task automatic test_stall_redirect();
    apply_reset();
    tick(); tick(); tick();  // boot, load 0, load 4 -> pc 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_addr !== 64'd8 || if_id_pc !== 64'd4 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold got addr %h pc %h v %b want 8/4/1", instr_addr, if_id_pc, if_id_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_pc !== 64'd8 || if_id_instr !== rom[2]) begin
      errors++; $display("FAIL stall_release got %h/%h want 8/%h", if_id_pc, if_id_instr, rom[2]);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h40;
    tick();
    checks++; if (instr_addr !== 64'h40 || if_id_valid !== 1'b0 || if_id_pc !== 64'd8) begin
      errors++; $display("FAIL redir_flush got %h/%b/%h want 40/0/8", instr_addr, if_id_valid, if_id_pc);
    end
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    checks++; if (if_id_pc !== 64'h40 || if_id_valid !== 1'b1 || if_id_instr !== rom[16]) begin
      errors++; $display("FAIL redir_load got %h/%b/%h want 40/1/%h", if_id_pc, if_id_valid, if_id_instr, rom[16]);
    end
  endtask

  task automatic test_end_of_rom();
    apply_reset();
    tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++; if (if_id_pc !== 64'(i * 4) || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL run_pc got %h/%b want %h/1", if_id_pc, if_id_valid, 64'(i * 4));
      end
    end
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 64'd1024 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL end_fault got %b/%h/%b want 1/400/0", fault, fault_pc, if_id_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    tick(); tick();
    redirect_valid = 1'b0;
    checks++; if (instr_addr !== 64'd1024 || fault !== 1'b1 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL fault_sticky got %h/%b/%b want 400/1/0", instr_addr, fault, if_id_valid);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h22;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_addr !== 64'h22 || fault !== 1'b0) begin
      errors++; $display("FAIL mis_arrive got %h/%b want 22/0", instr_addr, fault);
    end
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 64'h22 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0) begin
      errors++; $display("FAIL mis_fault got %b/%h/%b/%h want 1/22/0/0", fault, fault_pc, if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_async_reset();
    // Reset while in FAULT (left there by the previous test)
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || fault_pc !== 64'h0 || instr_addr !== 64'h0) begin
      errors++; $display("FAIL areset_fault got %b/%h/%h want 0/0/0", fault, fault_pc, instr_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick(); tick();
    stall = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== 32'h0 || instr_addr !== 64'h0) begin
      errors++; $display("FAIL areset_stall got %b/%h/%h/%h want 0/0/0/0", if_id_valid, if_id_pc, if_id_instr, instr_addr);
    end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd0 || perf_stall_cyc !== 32'd0 || perf_flushes !== 32'd0) begin
      errors++; $display("FAIL areset_perf got %0d/%0d/%0d want 0/0/0", perf_fetched, perf_stall_cyc, perf_flushes);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1; stall = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL areset_boot got %b want 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== rom[0]) begin
      errors++; $display("FAIL areset_fetch got %b/%h/%h want 1/0/%h", if_id_valid, if_id_pc, if_id_instr, rom[0]);
    end
  endtask

  task automatic test_random();
    int unsigned sel;
    apply_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        apply_reset();
        model_reset();
      end
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 15);
      if (sel < 12) redirect_pc = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (sel < 14) redirect_pc = 64'($urandom_range(0, 1023));
      else if (sel == 14) redirect_pc = 64'd1020;
      else redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      model_step();
      tick();
      checks++; if (instr_addr !== m_pc) begin
        errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, instr_addr, m_pc);
      end
      checks++; if (if_id_valid !== m_valid || if_id_pc !== m_ipc || if_id_instr !== m_instr) begin
        errors++; $display("FAIL rnd_ifid n=%0d got %b/%h/%h want %b/%h/%h", n, if_id_valid, if_id_pc,
                           if_id_instr, m_valid, m_ipc, m_instr);
      end
      checks++; if (fault !== m_fault || fault_pc !== m_fpc) begin
        errors++; $display("FAIL rnd_fault n=%0d got %b/%h want %b/%h", n, fault, fault_pc, m_fault, m_fpc);
      end
`ifdef FETCH_PERF_EN
      checks++; if (perf_fetched !== 32'(m_fetched) || perf_stall_cyc !== 32'(m_stalls) ||
                    perf_flushes !== 32'(m_flushes)) begin
        errors++; $display("FAIL rnd_perf n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, perf_fetched,
                           perf_stall_cyc, perf_flushes, m_fetched, m_stalls, m_flushes);
      end
`endif
    end
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    test_seq_fetch();
    test_stall_redirect();
    test_end_of_rom();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
